conv_result_streamer: RTL and testbench

Drain side of the 1-D convolution engine. It captures the engine's 30-entry signed result array on the engine's one-cycle done pulse. It then streams the entries one per beat over a valid/ready interface to downstream logic (line/edge detection, host FIFO). While streaming, it tracks the largest-magnitude result and its index, and reports it once after the last beat.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_result_streamer_if.sv | 14 +
 rtl/peak_tracker.sv | 31 +++
 rtl/conv_result_streamer.sv | 98 +++++++++
 tb/tb_conv_result_streamer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and types for the convolution engine and its result streamer
package conv_pkg;
  localparam int NUM_RESULTS = 30;
  localparam int RESULT_W    = 18;
  localparam int IDX_W       = $clog2(NUM_RESULTS);

  typedef logic signed [RESULT_W-1:0] result_t;
  typedef logic [IDX_W-1:0]           idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_REPORT
  } streamer_state_t;
endpackage

// File: rtl/conv_result_streamer_if.sv
// rtl/conv_result_streamer_if.sv - valid/ready result stream carrying data, index and last flag
interface conv_result_streamer_if #(
  parameter int DATA_W = conv_pkg::RESULT_W,
  parameter int IDX_W  = conv_pkg::IDX_W
);
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]         m_index;
  logic                     m_last;

  modport master (output m_valid, m_data, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

// File: rtl/peak_tracker.sv
// rtl/peak_tracker.sv - running max |value| with index; first entry wins on ties
module peak_tracker #(
  parameter int DATA_W = conv_pkg::RESULT_W,
  parameter int IDX_W  = conv_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] value,
  input  logic [IDX_W-1:0]         index,
  output logic [DATA_W-1:0]        peak_value,
  output logic [IDX_W-1:0]         peak_index
);
  logic [DATA_W-1:0] value_u;
  logic [DATA_W-1:0] mag;

  // Unsigned result is wide enough that the most negative input needs no saturation.
  assign value_u = value;
  assign mag     = value[DATA_W-1] ? (~value_u + DATA_W'(1)) : value_u;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      peak_value <= '0;
      peak_index <= '0;
    end else if (update && (mag > peak_value)) begin
      peak_value <= mag;
      peak_index <= index;
    end
  end
endmodule

// File: rtl/conv_result_streamer.sv
// rtl/conv_result_streamer.sv - captures a convolution row and streams it out with a peak report
module conv_result_streamer
  import conv_pkg::*;
#(
  parameter int NUM_RESULTS = conv_pkg::NUM_RESULTS,
  parameter int DATA_W      = conv_pkg::RESULT_W,
  parameter int IDX_W       = $clog2(NUM_RESULTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_in,
  input  logic signed [DATA_W-1:0] result_in [NUM_RESULTS],
  conv_result_streamer_if.master   m,
  output logic                     busy,
  output logic                     overrun,
  output logic                     peak_valid,
  output logic [DATA_W-1:0]        peak_value,
  output logic [IDX_W-1:0]         peak_index
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESULTS - 1);

  streamer_state_t          state, state_next;
  logic signed [DATA_W-1:0] row_buf [NUM_RESULTS];
  logic signed [DATA_W-1:0] cur_data;
  logic [IDX_W-1:0]         idx;
  logic                     capture;
  logic                     handshake;
  logic                     at_last;

  assign capture   = (state == ST_IDLE) && done_in;
  assign handshake = (state == ST_STREAM) && m.m_ready;
  assign at_last   = (idx == LAST_IDX);
  assign cur_data  = row_buf[idx];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    m.m_valid  = 1'b0;
    m.m_data   = '0;
    m.m_index  = '0;
    m.m_last   = 1'b0;
    busy       = 1'b1;
    peak_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (capture) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        m.m_valid = 1'b1;
        m.m_data  = cur_data;
        m.m_index = idx;
        m.m_last  = at_last;
        if (handshake && at_last) state_next = ST_REPORT;
      end
      ST_REPORT: begin
        peak_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Buffer only loads from IDLE, so a late done_in cannot corrupt the row in flight.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NUM_RESULTS; k++) row_buf[k] <= result_in[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || capture)           idx <= '0;
    else if (handshake && !at_last) idx <= idx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                            overrun <= 1'b0;
    else if (done_in && (state != ST_IDLE)) overrun <= 1'b1;
  end

  peak_tracker #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_peak_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (capture),
    .update     (handshake),
    .value      (cur_data),
    .index      (idx),
    .peak_value (peak_value),
    .peak_index (peak_index)
  );
endmodule

// File: tb/tb_conv_result_streamer.sv
// tb/tb_conv_result_streamer.sv - directed bench for conv_result_streamer
module tb_conv_result_streamer;
  localparam int N = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done_in = 1'b0;
  logic signed [17:0] result_in [N];
  logic busy, overrun, peak_valid;
  logic [17:0] peak_value;
  logic [4:0]  peak_index;

  conv_result_streamer_if #(.DATA_W(18), .IDX_W(5)) m_if ();

  conv_result_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .done_in    (done_in),
    .result_in  (result_in),
    .m          (m_if),
    .busy       (busy),
    .overrun    (overrun),
    .peak_valid (peak_valid),
    .peak_value (peak_value),
    .peak_index (peak_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ramp;
    int i1;
    int v1;
    int i2;
    int v2;
    int exp_pv;
    int exp_pi;
  } vec_t;

  vec_t vecs [6];
  logic signed [17:0] exp_row [N];
  logic signed [17:0] alt_row [N];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic build(input vec_t v);
    for (int k = 0; k < N; k++) begin
      if (v.ramp) exp_row[k] = 18'(k - 15);
      else        exp_row[k] = '0;
    end
    if (v.i1 >= 0) exp_row[v.i1] = 18'(v.v1);
    if (v.i2 >= 0) exp_row[v.i2] = 18'(v.v2);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_valid"}, m_if.m_valid, 0);
    check({tag, "_m_data"}, m_if.m_data, 0);
    check({tag, "_m_index"}, m_if.m_index, 0);
    check({tag, "_m_last"}, m_if.m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_peak_valid"}, peak_valid, 0);
    check({tag, "_peak_value"}, peak_value, 0);
    check({tag, "_peak_index"}, peak_index, 0);
  endtask

  task automatic pulse_done();
    for (int k = 0; k < N; k++) result_in[k] = exp_row[k];
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
    check("capture_busy", busy, 1);
  endtask

  // Called in the first STREAM cycle; returns in the IDLE cycle after the report.
  task automatic stream_row(input bit rnd, input int inject_at, input int abort_at,
                            input int exp_pv, input int exp_pi);
    int beats = 0;
    int cycles = 0;
    bit injected = 1'b0;
    while (beats < N && cycles < 500) begin
      done_in = 1'b0;
      if (beats == abort_at) begin
        rst = 1'b1;
        m_if.m_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("abort");
        return;
      end
      if (beats == inject_at && !injected) begin
        injected = 1'b1;
        done_in = 1'b1;
        for (int k = 0; k < N; k++) result_in[k] = alt_row[k];
      end
      m_if.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("beat_valid", m_if.m_valid, 1);
      check("beat_data", m_if.m_data, exp_row[beats]);
      check("beat_index", m_if.m_index, beats);
      check("beat_last", m_if.m_last, (beats == N - 1));
      check("beat_no_peak", peak_valid, 0);
      @(posedge clk); #1;
      if (m_if.m_ready) beats++;
      cycles++;
    end
    done_in = 1'b0;
    check("stream_timeout", (cycles < 500), 1);
    m_if.m_ready = 1'($urandom_range(0, 1));
    check("report_pulse", peak_valid, 1);
    check("report_value", peak_value, exp_pv);
    check("report_index", peak_index, exp_pi);
    check("report_valid_low", m_if.m_valid, 0);
    @(posedge clk); #1;
    check("post_pulse", peak_valid, 0);
    check("post_busy", busy, 0);
    check("hold_value", peak_value, exp_pv);
    check("hold_index", peak_index, exp_pi);
    m_if.m_ready = 1'b1;
  endtask

  initial begin
    int pulses;
    m_if.m_ready = 1'b0;
    for (int k = 0; k < N; k++) result_in[k] = '0;
    vecs[0] = '{1'b1, -1, 0, -1, 0, 15, 0};
    vecs[1] = '{1'b0, 3, 100, 20, -100, 100, 3};
    vecs[2] = '{1'b0, 7, -131072, -1, 0, 131072, 7};
    vecs[3] = '{1'b0, -1, 0, -1, 0, 0, 0};
    vecs[4] = '{1'b0, 0, -131071, 29, 131071, 131071, 0};
    vecs[5] = '{1'b0, 15, -5, 16, 6, 6, 16};

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready_low_busy", busy, 0);

    // Consecutive rows land done_in exactly one cycle after busy falls.
    for (int i = 0; i < 6; i++) begin
      build(vecs[i]);
      pulse_done();
      stream_row(1'b0, -1, -1, vecs[i].exp_pv, vecs[i].exp_pi);
    end
    check("b2b_no_overrun", overrun, 0);

    build(vecs[0]);
    pulse_done();
    stream_row(1'b1, -1, -1, 15, 0);

    build(vecs[2]);
    for (int k = 0; k < N; k++) alt_row[k] = exp_row[k];
    build(vecs[0]);
    pulse_done();
    stream_row(1'b0, 10, -1, 15, 0);
    check("overrun_set", overrun, 1);
    build(vecs[2]);
    pulse_done();
    stream_row(1'b0, -1, -1, 131072, 7);
    check("overrun_sticky", overrun, 1);

    build(vecs[0]);
    pulse_done();
    stream_row(1'b0, -1, 12, 0, 0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (peak_valid) pulses++;
      @(posedge clk); #1;
    end
    check("abort_no_peak", pulses, 0);
    check("abort_idle", busy, 0);

    build(vecs[1]);
    pulse_done();
    stream_row(1'b0, -1, -1, 100, 3);
    build(vecs[5]);
    pulse_done();
    stream_row(1'b0, -1, -1, 6, 16);
    check("after_reset_overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
